// File: rtl/s_fold_sig_8bit.sv
// Frame signature folder: accumulates rotate-and-XOR signatures of two byte lanes
// over a frame of frame_len+1 beats, then holds the result for a ready/valid handshake.
module s_fold_sig_8bit #(
    parameter int unsigned CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         aa,
    input  logic [7:0]         bb,
    input  logic [CNT_W-1:0]   frame_len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         sig_a,
    output logic [7:0]         sig_b,
    output logic [CNT_W:0]     out_beats
);

    localparam int unsigned BW = CNT_W + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [7:0]    sig_a_q, sig_a_d;
    logic [7:0]    sig_b_q, sig_b_d;
    logic [BW-1:0] beats_q, beats_d;
    logic [BW-1:0] n_q, n_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          accept;
    logic [BW-1:0] beats_inc;

    assign accept    = in_valid && in_ready_q;
    assign beats_inc = beats_q + BW'(1);

    // Next-state and datapath update; only an accepted beat touches the signature.
    always_comb begin
        state_d = state_q;
        sig_a_d = sig_a_q;
        sig_b_d = sig_b_q;
        beats_d = beats_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    n_d     = BW'(frame_len) + BW'(1);
                    sig_a_d = aa;
                    sig_b_d = bb;
                    beats_d = BW'(1);
                    state_d = (frame_len == CNT_W'(0)) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    sig_a_d = {sig_a_q[6:0], sig_a_q[7]} ^ aa;
                    sig_b_d = {sig_b_q[6:0], sig_b_q[7]} ^ bb;
                    beats_d = beats_inc;
                    if (beats_inc == n_q) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d != HOLD);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sig_a_q     <= 8'h00;
            sig_b_q     <= 8'h00;
            beats_q     <= '0;
            n_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_a_q     <= sig_a_d;
            sig_b_q     <= sig_b_d;
            beats_q     <= beats_d;
            n_q         <= n_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sig_a     = sig_a_q;
    assign sig_b     = sig_b_q;
    assign out_beats = beats_q;

endmodule
